// File: rtl/idelay_tap_model_if.sv
// Control, data and readout signals of the tap-delay model.
interface idelay_tap_model_if;
   logic       REGRST;
   logic       LD;
   logic       CE;
   logic       INC;
   logic       CINVCTRL;
   logic [4:0] CNTVALUEIN;
   logic       LDPIPEEN;
   logic       IDATAIN;
   logic       DATAIN;
   logic       DATAOUT;
   logic [4:0] CNTVALUEOUT;
   logic [11:0] DELAY_PS;

   // Driver side: the capture logic / testbench.
   modport master (
      output REGRST, LD, CE, INC, CINVCTRL, CNTVALUEIN, LDPIPEEN, IDATAIN, DATAIN,
      input  DATAOUT, CNTVALUEOUT, DELAY_PS
   );

   // Delay model side.
   modport slave (
      input  REGRST, LD, CE, INC, CINVCTRL, CNTVALUEIN, LDPIPEEN, IDATAIN, DATAIN,
      output DATAOUT, CNTVALUEOUT, DELAY_PS
   );
endinterface

// File: rtl/idelay_tap_model.sv
// Cycle-based model of the 7-series input delay: tap register, optional load pipe
// register and a 31-deep shift line standing in for the analog tap chain.
module idelay_tap_model #(
   parameter string IDELAY_TYPE           = "FIXED",
   parameter string DELAY_SRC             = "IDATAIN",
   parameter int    IDELAY_VALUE          = 0,
   parameter string HIGH_PERFORMANCE_MODE = "FALSE",
   parameter string SIGNAL_PATTERN        = "DATA",
   parameter int    REFCLK_FREQUENCY      = 200,
   parameter string CINVCTRL_SEL          = "FALSE",
   parameter string PIPE_SEL              = "FALSE"
) (
   input logic               clk,
   input logic               rst_n,
   idelay_tap_model_if.slave dly
);

   localparam bit IS_FIXED = (IDELAY_TYPE == "FIXED");
   localparam bit IS_VLOAD = (IDELAY_TYPE == "VAR_LOAD");
   localparam bit IS_PIPE  = (IDELAY_TYPE == "VAR_LOAD_PIPE");
   localparam bit TYPE_OK  = IS_FIXED || IS_VLOAD || IS_PIPE || (IDELAY_TYPE == "VARIABLE");
   localparam bit SRC_OK   = (DELAY_SRC == "IDATAIN") || (DELAY_SRC == "DATAIN");
   localparam bit HP_OK    = (HIGH_PERFORMANCE_MODE == "TRUE") ||
                             (HIGH_PERFORMANCE_MODE == "FALSE");
   localparam bit PAT_OK   = (SIGNAL_PATTERN == "DATA") || (SIGNAL_PATTERN == "CLOCK");
   localparam bit CINV_OK  = (CINVCTRL_SEL == "TRUE") || (CINVCTRL_SEL == "FALSE");
   localparam bit PSEL_OK  = (PIPE_SEL == "TRUE") || (PIPE_SEL == "FALSE");
   localparam bit VAL_OK   = (IDELAY_VALUE >= 0) && (IDELAY_VALUE <= 31);
   localparam bit FREQ_OK  = (REFCLK_FREQUENCY == 200) || (REFCLK_FREQUENCY == 400);
   localparam bit USE_CINV = (CINVCTRL_SEL == "TRUE");
   localparam bit USE_DIN  = (DELAY_SRC == "DATAIN");

   localparam logic [11:0] TAP_PS   = (REFCLK_FREQUENCY == 400) ? 12'd39 : 12'd78;
   localparam logic [4:0]  INIT_TAP = 5'(IDELAY_VALUE);

   // Reject illegal generic combinations at elaboration.
   if (!(TYPE_OK && SRC_OK && HP_OK && PAT_OK && CINV_OK && PSEL_OK)) begin : g_bad_string
      $fatal(1, "idelay_tap_model: illegal string parameter value");
   end
   if (!VAL_OK) begin : g_bad_value
      $fatal(1, "idelay_tap_model: IDELAY_VALUE must be 0..31");
   end
   if (!FREQ_OK) begin : g_bad_freq
      $fatal(1, "idelay_tap_model: REFCLK_FREQUENCY must be 200 or 400");
   end

   logic [4:0]  tap_q;
   logic [4:0]  pipe_q;
   logic [31:1] line_q;
   logic        src;
   logic        blocked;
   logic [4:0]  ld_value;
   logic [31:0] taps_all;

   // Source select, update blocking and load value selection.
   always_comb begin
      src      = USE_DIN ? dly.DATAIN : dly.IDATAIN;
      blocked  = USE_CINV && dly.CINVCTRL;
      ld_value = INIT_TAP;
      if (IS_PIPE) begin
         ld_value = pipe_q;
      end else if (IS_VLOAD) begin
         ld_value = dly.CNTVALUEIN;
      end
   end

   // Tap, pipe and delay-line state; reset overrides every other control.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tap_q  <= INIT_TAP;
         pipe_q <= '0;
         line_q <= '0;
      end else begin
         line_q <= {line_q[30:1], src};
         // Pipe keeps loading even while tap updates are blocked.
         if (IS_PIPE) begin
            if (dly.REGRST) begin
               pipe_q <= '0;
            end else if (dly.LDPIPEEN) begin
               pipe_q <= dly.CNTVALUEIN;
            end
         end
         if (!IS_FIXED && !blocked) begin
            if (dly.LD) begin
               tap_q <= ld_value;
            end else if (dly.CE) begin
               tap_q <= dly.INC ? tap_q + 5'd1 : tap_q - 5'd1;
            end
         end
      end
   end

   // Bit 0 is the undelayed source so tap 0 is a combinational pass-through.
   always_comb begin
      taps_all        = {line_q, src};
      dly.DATAOUT     = taps_all[tap_q];
      dly.CNTVALUEOUT = tap_q;
      dly.DELAY_PS    = 12'(tap_q) * TAP_PS;
   end

endmodule

// File: tb/tb_idelay_tap_model.sv
// Scoreboard bench for idelay_tap_model: five configurations share one clock.
module tb_idelay_tap_model;

   typedef struct {
      string tag;
      int    sel;
      int    exp;
   } sb_item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_n_e = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   sb_item_t sb_q[$];

   always #5 clk = ~clk;

   idelay_tap_model_if if_a ();
   idelay_tap_model_if if_b ();
   idelay_tap_model_if if_c ();
   idelay_tap_model_if if_d ();
   idelay_tap_model_if if_e ();

   idelay_tap_model #(.IDELAY_TYPE("FIXED"), .IDELAY_VALUE(3), .REFCLK_FREQUENCY(200))
      dut_a (.clk(clk), .rst_n(rst_n), .dly(if_a));
   idelay_tap_model #(.IDELAY_TYPE("VARIABLE"), .IDELAY_VALUE(30))
      dut_b (.clk(clk), .rst_n(rst_n), .dly(if_b));
   idelay_tap_model #(.IDELAY_TYPE("VAR_LOAD"), .IDELAY_VALUE(0), .REFCLK_FREQUENCY(400))
      dut_c (.clk(clk), .rst_n(rst_n), .dly(if_c));
   idelay_tap_model #(.IDELAY_TYPE("VAR_LOAD_PIPE"), .DELAY_SRC("DATAIN"), .IDELAY_VALUE(0))
      dut_d (.clk(clk), .rst_n(rst_n), .dly(if_d));
   idelay_tap_model #(.IDELAY_TYPE("VAR_LOAD"), .IDELAY_VALUE(4), .CINVCTRL_SEL("TRUE"))
      dut_e (.clk(clk), .rst_n(rst_n_e), .dly(if_e));

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int obs_of(input int sel);
      case (sel)
         0:       return int'(if_a.DATAOUT);
         1:       return int'(if_a.CNTVALUEOUT);
         2:       return int'(if_a.DELAY_PS);
         3:       return int'(if_b.CNTVALUEOUT);
         4:       return int'(if_c.CNTVALUEOUT);
         5:       return int'(if_c.DELAY_PS);
         6:       return int'(if_d.CNTVALUEOUT);
         7:       return int'(if_d.DATAOUT);
         8:       return int'(if_e.CNTVALUEOUT);
         9:       return int'(if_e.DATAOUT);
         default: return -1;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input int exp);
      sb_item_t it;
      it.tag = tag;
      it.sel = sel;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic drain();
      sb_item_t it;
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         check_eq(it.tag, obs_of(it.sel), it.exp);
      end
   endtask

   // One clock edge, then compare everything expected after it.
   task automatic cyc();
      @(posedge clk);
      #1;
      drain();
   endtask

   // Combinational settle without a clock edge.
   task automatic settle();
      #1;
      drain();
   endtask

   task automatic idle_inputs(input int which);
      case (which)
         0: begin if_a.REGRST = 0; if_a.LD = 0; if_a.CE = 0; if_a.INC = 0; if_a.CINVCTRL = 0;
                  if_a.CNTVALUEIN = 0; if_a.LDPIPEEN = 0; if_a.IDATAIN = 0; if_a.DATAIN = 0; end
         1: begin if_b.REGRST = 0; if_b.LD = 0; if_b.CE = 0; if_b.INC = 0; if_b.CINVCTRL = 0;
                  if_b.CNTVALUEIN = 0; if_b.LDPIPEEN = 0; if_b.IDATAIN = 0; if_b.DATAIN = 0; end
         2: begin if_c.REGRST = 0; if_c.LD = 0; if_c.CE = 0; if_c.INC = 0; if_c.CINVCTRL = 0;
                  if_c.CNTVALUEIN = 0; if_c.LDPIPEEN = 0; if_c.IDATAIN = 0; if_c.DATAIN = 0; end
         3: begin if_d.REGRST = 0; if_d.LD = 0; if_d.CE = 0; if_d.INC = 0; if_d.CINVCTRL = 0;
                  if_d.CNTVALUEIN = 0; if_d.LDPIPEEN = 0; if_d.IDATAIN = 0; if_d.DATAIN = 0; end
         default: begin if_e.REGRST = 0; if_e.LD = 0; if_e.CE = 0; if_e.INC = 0;
                  if_e.CINVCTRL = 0; if_e.CNTVALUEIN = 0; if_e.LDPIPEEN = 0; if_e.IDATAIN = 0;
                  if_e.DATAIN = 0; end
      endcase
   endtask

   initial begin
      for (int i = 0; i < 5; i++) idle_inputs(i);
      rst_n   = 1'b0;
      rst_n_e = 1'b0;
      cyc();
      cyc();
      rst_n   = 1'b1;
      rst_n_e = 1'b1;

      // Reset state of every instance.
      push("rst_a_tap", 1, 3);
      push("rst_a_ps", 2, 234);
      push("rst_a_out", 0, 0);
      push("rst_b_tap", 3, 30);
      push("rst_c_tap", 4, 0);
      push("rst_c_ps", 5, 0);
      push("rst_d_tap", 6, 0);
      push("rst_e_tap", 8, 4);
      push("rst_e_out", 9, 0);
      settle();

      // FIXED: one-cycle pulse must reappear exactly three cycles later.
      if_a.IDATAIN = 1'b1;
      push("fix_pulse_c1", 0, 0);
      cyc();
      if_a.IDATAIN = 1'b0;
      push("fix_pulse_c2", 0, 0);
      cyc();
      push("fix_pulse_c3", 0, 1);
      cyc();
      push("fix_pulse_c4", 0, 0);
      cyc();
      // FIXED ignores every control input.
      for (int i = 0; i < 4; i++) begin
         if_a.LD = i[0];
         if_a.CE = 1'b1;
         if_a.INC = i[1];
         if_a.CNTVALUEIN = 5'd20;
         if_a.LDPIPEEN = 1'b1;
         push("fix_hold_tap", 1, 3);
         push("fix_hold_ps", 2, 234);
         cyc();
      end
      idle_inputs(0);

      // VARIABLE: increment wraps 31 -> 0, decrement wraps back, LD restores 30.
      if_b.CE = 1'b1;
      if_b.INC = 1'b1;
      push("var_inc1", 3, 31);
      cyc();
      push("var_inc2", 3, 0);
      cyc();
      push("var_inc3", 3, 1);
      cyc();
      if_b.INC = 1'b0;
      push("var_dec", 3, 0);
      cyc();
      push("var_dec_wrap", 3, 31);
      cyc();
      if_b.CE = 1'b0;
      if_b.LD = 1'b1;
      push("var_ld", 3, 30);
      cyc();
      idle_inputs(1);

      // VAR_LOAD at 400 MHz.
      if_c.CNTVALUEIN = 5'd17;
      if_c.LD = 1'b1;
      push("vl_ld17", 4, 17);
      push("vl_ps663", 5, 663);
      cyc();
      if_c.CNTVALUEIN = 5'd5;
      if_c.CE = 1'b1;
      if_c.INC = 1'b1;
      push("vl_ld_wins", 4, 5);
      cyc();
      if_c.LD = 1'b0;
      if_c.INC = 1'b0;
      push("vl_dec", 4, 4);
      push("vl_dec_ps", 5, 156);
      cyc();
      idle_inputs(2);

      // VAR_LOAD_PIPE.
      if_d.CNTVALUEIN = 5'd9;
      if_d.LDPIPEEN = 1'b1;
      push("pipe_cap_hold", 6, 0);
      cyc();
      if_d.LDPIPEEN = 1'b0;
      if_d.LD = 1'b1;
      push("pipe_ld9", 6, 9);
      cyc();
      if_d.CNTVALUEIN = 5'd5;
      if_d.LDPIPEEN = 1'b1;
      push("pipe_ld_pre", 6, 9);
      cyc();
      if_d.LDPIPEEN = 1'b0;
      push("pipe_ld5", 6, 5);
      cyc();
      // REGRST beats a coincident LDPIPEEN.
      if_d.LD = 1'b0;
      if_d.REGRST = 1'b1;
      if_d.LDPIPEEN = 1'b1;
      if_d.CNTVALUEIN = 5'd7;
      push("pipe_rr_hold", 6, 5);
      cyc();
      if_d.REGRST = 1'b0;
      if_d.LDPIPEEN = 1'b0;
      if_d.LD = 1'b1;
      push("pipe_ld_cleared", 6, 0);
      cyc();
      if_d.LD = 1'b0;
      // DATAIN source at tap 0: combinational follow, IDATAIN ignored.
      if_d.DATAIN = 1'b1;
      if_d.IDATAIN = 1'b0;
      push("din_hi", 7, 1);
      settle();
      if_d.DATAIN = 1'b0;
      if_d.IDATAIN = 1'b1;
      push("din_lo_idata_hi", 7, 0);
      settle();
      if_d.DATAIN = 1'b1;
      push("din_hi2", 7, 1);
      settle();
      idle_inputs(3);

      // Mid-run reset and CINVCTRL blocking on instance e.
      if_e.IDATAIN = 1'b1;
      if_e.CNTVALUEIN = 5'd12;
      if_e.LD = 1'b1;
      push("e_ld12", 8, 12);
      cyc();
      if_e.LD = 1'b0;
      for (int i = 0; i < 12; i++) cyc();
      push("e_line_full", 9, 1);
      settle();
      if_e.CINVCTRL = 1'b1;
      if_e.CE = 1'b1;
      if_e.INC = 1'b1;
      push("e_cinv_ce", 8, 12);
      cyc();
      if_e.LD = 1'b1;
      if_e.CNTVALUEIN = 5'd2;
      push("e_cinv_ld", 8, 12);
      cyc();
      if_e.CINVCTRL = 1'b0;
      rst_n_e = 1'b0;
      push("e_rst_tap", 8, 4);
      push("e_rst_out", 9, 0);
      cyc();
      rst_n_e = 1'b1;
      if_e.LD = 1'b0;
      if_e.CE = 1'b0;
      push("e_post_rst1", 9, 0);
      cyc();
      push("e_post_rst2", 9, 0);
      cyc();
      push("e_post_rst3", 9, 0);
      cyc();
      push("e_post_rst4", 9, 1);
      push("e_post_rst_tap", 8, 4);
      cyc();

      check_eq("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
